// File: rtl/bsg_dmc_ui_arbiter.sv
// Round-robin arbiter sharing one bsg_dmc app_* interface between two requesters.
// Optional performance counters are enabled with `define BSG_DMC_UI_ARB_PERF_EN.
module bsg_dmc_ui_arbiter #(
   parameter int unsigned ui_addr_width_p = 28,
   parameter int unsigned ui_data_width_p = 128,
   parameter int unsigned ui_burst_len_p  = 2,
   parameter int unsigned max_reads_p     = 8
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic [1:0][ui_addr_width_p-1:0]          req_app_addr_i,
   input  logic [1:0][2:0]                          req_app_cmd_i,
   input  logic [1:0]                               req_app_en_i,
   output logic [1:0]                               req_app_rdy_o,
   input  logic [1:0]                               req_app_wdf_wren_i,
   input  logic [1:0][ui_data_width_p-1:0]          req_app_wdf_data_i,
   input  logic [1:0][(ui_data_width_p>>3)-1:0]     req_app_wdf_mask_i,
   input  logic [1:0]                               req_app_wdf_end_i,
   output logic [1:0]                               req_app_wdf_rdy_o,
   output logic [1:0]                               req_app_rd_data_valid_o,
   output logic [ui_data_width_p-1:0]               req_app_rd_data_o,
   output logic [1:0]                               req_app_rd_data_end_o,
   output logic [ui_addr_width_p-1:0]               app_addr_o,
   output logic [2:0]                               app_cmd_o,
   output logic                                     app_en_o,
   input  logic                                     app_rdy_i,
   output logic                                     app_wdf_wren_o,
   output logic [ui_data_width_p-1:0]               app_wdf_data_o,
   output logic [(ui_data_width_p>>3)-1:0]          app_wdf_mask_o,
   output logic                                     app_wdf_end_o,
   input  logic                                     app_wdf_rdy_i,
   input  logic                                     app_rd_data_valid_i,
   input  logic [ui_data_width_p-1:0]               app_rd_data_i,
   input  logic                                     app_rd_data_end_i,
`ifdef BSG_DMC_UI_ARB_PERF_EN
   output logic [1:0][31:0]                         grant_count_o,
   output logic [31:0]                              stall_count_o,
`endif
   output logic                                     rd_orphan_o
);

   localparam int unsigned ptr_width_lp  = $clog2(max_reads_p);
   localparam int unsigned cnt_width_lp  = $clog2(max_reads_p + 1);
   localparam int unsigned beat_width_lp = (ui_burst_len_p > 1) ? $clog2(ui_burst_len_p) : 1;
   localparam logic [2:0]  cmd_write_lp  = 3'b000;
   localparam logic [2:0]  cmd_read_lp   = 3'b001;

   typedef enum logic [1:0] {eIdle, eCmd, eWdata} state_e;

   state_e                    state_q, state_d;
   logic                      grant_q, grant_d;
   logic                      last_q, last_d;
   logic [beat_width_lp-1:0]  beat_q, beat_d;
   logic [max_reads_p-1:0]    id_mem_q;
   logic [ptr_width_lp-1:0]   wr_ptr_q, rd_ptr_q;
   logic [cnt_width_lp-1:0]   count_q, count_d;
   logic                      orphan_q;

   logic fifo_full, fifo_empty, head_id, rd_hit, push, pop;
   logic cmd_is_rd, cmd_is_wr, block, cmd_hs, wdf_hs;

   assign fifo_full  = (count_q == cnt_width_lp'(max_reads_p));
   assign fifo_empty = (count_q == '0);
   assign head_id    = id_mem_q[rd_ptr_q];

   assign cmd_is_rd  = (req_app_cmd_i[grant_q] == cmd_read_lp);
   assign cmd_is_wr  = (req_app_cmd_i[grant_q] == cmd_write_lp);
   // A read is held off while every ID slot is taken; an end-pop this cycle does not free one.
   assign block      = cmd_is_rd & fifo_full;
   assign cmd_hs     = req_app_en_i[grant_q] & app_rdy_i & ~block;
   assign wdf_hs     = req_app_wdf_wren_i[grant_q] & app_wdf_rdy_i;

   // Command / write-data steering and next-state logic.
   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      last_d            = last_q;
      beat_d            = beat_q;
      push              = 1'b0;
      req_app_rdy_o     = '0;
      req_app_wdf_rdy_o = '0;
      app_en_o          = 1'b0;
      app_wdf_wren_o    = 1'b0;
      app_addr_o        = req_app_addr_i[grant_q];
      app_cmd_o         = req_app_cmd_i[grant_q];
      app_wdf_data_o    = req_app_wdf_data_i[grant_q];
      app_wdf_mask_o    = req_app_wdf_mask_i[grant_q];
      app_wdf_end_o     = req_app_wdf_end_i[grant_q];
      unique case (state_q)
         eIdle: begin
            if (|req_app_en_i) begin
               grant_d = (&req_app_en_i) ? ~last_q : req_app_en_i[1];
               state_d = eCmd;
            end
         end
         eCmd: begin
            app_en_o               = req_app_en_i[grant_q] & ~block;
            req_app_rdy_o[grant_q] = app_rdy_i & ~block;
            if (!req_app_en_i[grant_q]) begin
               state_d = eIdle;
            end else if (cmd_hs) begin
               if (cmd_is_wr) begin
                  state_d = eWdata;
                  beat_d  = '0;
               end else begin
                  state_d = eIdle;
                  last_d  = grant_q;
                  push    = cmd_is_rd;
               end
            end
         end
         eWdata: begin
            app_wdf_wren_o             = req_app_wdf_wren_i[grant_q];
            req_app_wdf_rdy_o[grant_q] = app_wdf_rdy_i;
            if (wdf_hs) begin
               beat_d = (beat_q == beat_width_lp'(ui_burst_len_p - 1)) ? '0 : beat_q + beat_width_lp'(1);
               if (req_app_wdf_end_i[grant_q]) begin
                  state_d = eIdle;
                  last_d  = grant_q;
                  beat_d  = '0;
               end
            end
         end
         default: state_d = eIdle;
      endcase
   end

   // Read return routing to the oldest outstanding issuer.
   assign rd_hit                  = app_rd_data_valid_i & ~fifo_empty;
   assign pop                     = rd_hit & app_rd_data_end_i;
   assign req_app_rd_data_valid_o = {head_id, ~head_id} & {2{rd_hit}};
   assign req_app_rd_data_end_o   = {head_id, ~head_id} & {2{pop}};
   assign req_app_rd_data_o       = app_rd_data_valid_i ? app_rd_data_i : '0;
   assign rd_orphan_o             = orphan_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + cnt_width_lp'(1);
      else if (pop && !push) count_d = count_q - cnt_width_lp'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= eIdle;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         beat_q   <= '0;
         id_mem_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         orphan_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         count_q <= count_d;
         if (push) begin
            id_mem_q[wr_ptr_q] <= grant_q;
            wr_ptr_q           <= wr_ptr_q + ptr_width_lp'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + ptr_width_lp'(1);
         if (app_rd_data_valid_i && fifo_empty) orphan_q <= 1'b1;
      end
   end

`ifdef BSG_DMC_UI_ARB_PERF_EN
   logic [1:0][31:0] grant_cnt_q;
   logic [31:0]      stall_cnt_q;
   logic             acc_c, stall_c;

   assign acc_c   = (state_q == eCmd) & cmd_hs;
   assign stall_c = (state_q == eCmd) & req_app_en_i[grant_q] & ~req_app_rdy_o[grant_q];

   // Saturating event counters.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (acc_c && (grant_cnt_q[grant_q] != '1))
            grant_cnt_q[grant_q] <= grant_cnt_q[grant_q] + 32'(1);
         if (stall_c && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'(1);
      end
   end

   assign grant_count_o = grant_cnt_q;
   assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
// Scoreboard bench for bsg_dmc_ui_arbiter: arbitration, write bursts, read routing, reset.
module tb_bsg_dmc_ui_arbiter;

   localparam logic [2:0] RD = 3'b001;
   localparam logic [2:0] WR = 3'b000;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0][27:0]      req_addr;
   logic [1:0][2:0]       req_cmd;
   logic [1:0]            req_en, req_rdy;
   logic [1:0]            wren, wend, wdf_rdy;
   logic [1:0][127:0]     wdata;
   logic [1:0][15:0]      wmask;
   logic [1:0]            rd_valid, rd_end;
   logic [127:0]          rd_data;
   logic [27:0]           app_addr;
   logic [2:0]            app_cmd;
   logic                  app_en, app_rdy;
   logic                  app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [127:0]          app_wdf_data;
   logic [15:0]           app_wdf_mask;
   logic                  dmc_rd_valid, dmc_rd_end;
   logic [127:0]          dmc_rd_data;
   logic                  orphan;

   int   total = 0;
   int   bad   = 0;
   bit   exp_rd_q[$];
   logic [127:0] wexp_q[$];
   logic [127:0] pat_a5, pat_5a;

   always #5 clk = ~clk;

   bsg_dmc_ui_arbiter dut (
      .clk_i(clk), .reset_i(rst),
      .req_app_addr_i(req_addr), .req_app_cmd_i(req_cmd), .req_app_en_i(req_en),
      .req_app_rdy_o(req_rdy),
      .req_app_wdf_wren_i(wren), .req_app_wdf_data_i(wdata), .req_app_wdf_mask_i(wmask),
      .req_app_wdf_end_i(wend), .req_app_wdf_rdy_o(wdf_rdy),
      .req_app_rd_data_valid_o(rd_valid), .req_app_rd_data_o(rd_data),
      .req_app_rd_data_end_o(rd_end),
      .app_addr_o(app_addr), .app_cmd_o(app_cmd), .app_en_o(app_en), .app_rdy_i(app_rdy),
      .app_wdf_wren_o(app_wdf_wren), .app_wdf_data_o(app_wdf_data), .app_wdf_mask_o(app_wdf_mask),
      .app_wdf_end_o(app_wdf_end), .app_wdf_rdy_i(app_wdf_rdy),
      .app_rd_data_valid_i(dmc_rd_valid), .app_rd_data_i(dmc_rd_data),
      .app_rd_data_end_i(dmc_rd_end),
      .rd_orphan_o(orphan)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One DMC read beat, compared against the oldest expected issuer.
   task automatic rd_beat(input logic [127:0] d, input logic e);
      bit id;
      dmc_rd_valid = 1'b1; dmc_rd_data = d; dmc_rd_end = e;
      @(negedge clk);
      if (exp_rd_q.size() != 0) begin
         id = exp_rd_q[0];
         check_eq("rd_valid", 128'(rd_valid), 128'(id ? 2'b10 : 2'b01));
         check_eq("rd_data", rd_data, d);
         check_eq("rd_end", 128'(rd_end), 128'(e ? (id ? 2'b10 : 2'b01) : 2'b00));
         if (e) void'(exp_rd_q.pop_front());
      end else begin
         check_eq("orphan_valid", 128'(rd_valid), 128'(0));
      end
      step();
      dmc_rd_valid = 1'b0; dmc_rd_end = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_rd_q.size() != 0; i++) begin
         rd_beat(rnd(), 1'b0);
         rd_beat(rnd(), 1'b1);
      end
   endtask

   // Single requester issues one command and waits (bounded) for its handshake.
   task automatic issue(input bit r, input logic [2:0] cmd, input logic [27:0] addr);
      bit done = 1'b0;
      req_en[r] = 1'b1; req_cmd[r] = cmd; req_addr[r] = addr;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge clk);
         if (req_rdy[r] && app_en) begin
            check_eq("issue_addr", 128'(app_addr), 128'(addr));
            done = 1'b1;
            if (cmd == RD) exp_rd_q.push_back(r);
         end
         step();
      end
      req_en[r] = 1'b0;
      check_eq("issue_done", 128'(done), 128'(1));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, acc, beat;
      bit exp_r;
      pat_a5 = {16{8'hA5}};
      pat_5a = {16{8'h5A}};
      rst = 1'b1; req_addr = '0; req_cmd = '0; req_en = '0; wren = '0; wend = '0;
      wdata = '0; wmask = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      dmc_rd_valid = 1'b0; dmc_rd_end = 1'b0; dmc_rd_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_app_en", 128'(app_en), 128'(0));
      check_eq("rst_req_rdy", 128'(req_rdy), 128'(0));
      check_eq("rst_wdf_rdy", 128'(wdf_rdy), 128'(0));
      check_eq("rst_wdf_wren", 128'(app_wdf_wren), 128'(0));
      check_eq("rst_orphan", 128'(orphan), 128'(0));
      step();
      rst = 1'b0;

      // single read from r0
      req_en[0] = 1'b1; req_cmd[0] = RD; req_addr[0] = 28'h100;
      @(negedge clk);
      check_eq("rd1_bubble_rdy", 128'(req_rdy), 128'(0));
      check_eq("rd1_bubble_en", 128'(app_en), 128'(0));
      step();
      @(negedge clk);
      check_eq("rd1_rdy", 128'(req_rdy), 128'(2'b01));
      check_eq("rd1_en", 128'(app_en), 128'(1));
      check_eq("rd1_cmd", 128'(app_cmd), 128'(RD));
      check_eq("rd1_addr", 128'(app_addr), 128'(28'h100));
      exp_rd_q.push_back(1'b0);
      step();
      req_en[0] = 1'b0;
      @(negedge clk);
      check_eq("rd1_idle_rdy", 128'(req_rdy), 128'(0));
      step();
      rd_beat(rnd(), 1'b0);
      rd_beat(rnd(), 1'b1);
      @(negedge clk);
      check_eq("rd1_quiet_valid", 128'(rd_valid), 128'(0));
      check_eq("rd1_quiet_data", rd_data, 128'(0));
      check_eq("rd1_no_orphan", 128'(orphan), 128'(0));
      step();

      // both requesters continuously: grants alternate, r1 first since r0 went last
      req_en = 2'b11; req_cmd[0] = RD; req_cmd[1] = RD;
      req_addr[0] = 28'hAAA; req_addr[1] = 28'hBBB;
      exp_r = 1'b1; n = 0;
      for (int i = 0; i < 20 && n < 6; i++) begin
         @(negedge clk);
         if (app_en && app_rdy) begin
            check_eq("rr_addr", 128'(app_addr), 128'(exp_r ? 28'hBBB : 28'hAAA));
            check_eq("rr_rdy", 128'(req_rdy), 128'(exp_r ? 2'b10 : 2'b01));
            exp_rd_q.push_back(exp_r);
            exp_r = ~exp_r;
            n++;
         end
         step();
      end
      req_en = '0;
      check_eq("rr_grants", 128'(n), 128'(6));
      drain();

      // r1 write with wdf_rdy 1,0,1 while r0 read waits
      wexp_q.push_back(pat_a5);
      wexp_q.push_back(pat_5a);
      req_en[1] = 1'b1; req_cmd[1] = WR; req_addr[1] = 28'h2000;
      @(negedge clk);
      check_eq("wr_bubble", 128'(req_rdy), 128'(0));
      step();
      req_en[0] = 1'b1; req_cmd[0] = RD; req_addr[0] = 28'h3000;
      wren[1] = 1'b1; wdata[1] = pat_a5; wmask[1] = 16'h00FF; wend[1] = 1'b0;
      @(negedge clk);
      check_eq("wr_cmd_rdy", 128'(req_rdy), 128'(2'b10));
      check_eq("wr_cmd_code", 128'(app_cmd), 128'(WR));
      check_eq("wr_early_rdy", 128'(wdf_rdy), 128'(0));
      check_eq("wr_early_wren", 128'(app_wdf_wren), 128'(0));
      step();
      req_en[1] = 1'b0;
      acc = 0; beat = 0;
      for (int k = 0; k < 8 && beat < 2; k++) begin
         app_wdf_rdy = (k % 2 == 0);
         wren[1] = 1'b1; wdata[1] = (beat == 0) ? pat_a5 : pat_5a; wend[1] = (beat == 1);
         @(negedge clk);
         check_eq("wr_r0_wait", 128'(req_rdy), 128'(0));
         check_eq("wr_wdf_rdy", 128'(wdf_rdy), 128'(app_wdf_rdy ? 2'b10 : 2'b00));
         if (app_wdf_wren && app_wdf_rdy) begin
            acc++;
            if (wexp_q.size() != 0) check_eq("wr_data", app_wdf_data, wexp_q.pop_front());
            check_eq("wr_mask", 128'(app_wdf_mask), 128'(16'h00FF));
            check_eq("wr_end", 128'(app_wdf_end), 128'(beat == 1));
         end
         if (wdf_rdy[1]) beat++;
         step();
      end
      wren = '0; wend = '0; app_wdf_rdy = 1'b1;
      check_eq("wr_beats", 128'(acc), 128'(2));
      @(negedge clk);
      check_eq("wr_done_rdy", 128'(req_rdy), 128'(0));
      check_eq("wr_done_wren", 128'(app_wdf_wren), 128'(0));
      step();
      @(negedge clk);
      check_eq("wr_then_rd_rdy", 128'(req_rdy), 128'(2'b01));
      check_eq("wr_then_rd_addr", 128'(app_addr), 128'(28'h3000));
      exp_rd_q.push_back(1'b0);
      step();
      req_en[0] = 1'b0;
      drain();

      // fill all 8 read IDs from r1, the 9th is held until the first end pops
      req_en[1] = 1'b1; req_cmd[1] = RD; req_addr[1] = 28'h4000;
      n = 0;
      for (int i = 0; i < 30 && n < 8; i++) begin
         @(negedge clk);
         if (req_rdy[1] && app_en) begin
            exp_rd_q.push_back(1'b1);
            n++;
         end
         step();
      end
      check_eq("full_issued", 128'(n), 128'(8));
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("full_en", 128'(app_en), 128'(0));
         check_eq("full_rdy", 128'(req_rdy), 128'(0));
         step();
      end
      rd_beat(rnd(), 1'b0);
      dmc_rd_valid = 1'b1; dmc_rd_end = 1'b1; dmc_rd_data = rnd();
      @(negedge clk);
      check_eq("full_pop_cycle_en", 128'(app_en), 128'(0));
      check_eq("full_pop_end", 128'(rd_end), 128'(2'b10));
      void'(exp_rd_q.pop_front());
      step();
      dmc_rd_valid = 1'b0; dmc_rd_end = 1'b0;
      @(negedge clk);
      check_eq("full_release_en", 128'(app_en), 128'(1));
      check_eq("full_release_rdy", 128'(req_rdy), 128'(2'b10));
      if (app_en && req_rdy[1]) exp_rd_q.push_back(1'b1);
      step();
      req_en[1] = 1'b0;
      drain();

      // interleaved reads r0, r1, r0 then an orphan beat
      issue(1'b0, RD, 28'h400);
      issue(1'b1, RD, 28'h500);
      issue(1'b0, RD, 28'h600);
      drain();
      rd_beat(rnd(), 1'b1);
      @(negedge clk);
      check_eq("orphan_set", 128'(orphan), 128'(1));
      step();
      @(negedge clk);
      check_eq("orphan_sticky", 128'(orphan), 128'(1));
      step();

      // reset in the middle of a write burst
      req_en[1] = 1'b1; req_cmd[1] = WR; req_addr[1] = 28'h700;
      step();
      @(negedge clk);
      check_eq("mid_cmd_rdy", 128'(req_rdy), 128'(2'b10));
      step();
      req_en[1] = 1'b0;
      wren[1] = 1'b1; wdata[1] = pat_a5; wend[1] = 1'b0;
      @(negedge clk);
      check_eq("mid_beat1_rdy", 128'(wdf_rdy), 128'(2'b10));
      step();
      wdata[1] = pat_5a; wend[1] = 1'b1;
      req_en = 2'b11; req_cmd[0] = RD; req_cmd[1] = RD;
      req_addr[0] = 28'hAAA; req_addr[1] = 28'hBBB;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_req_rdy", 128'(req_rdy), 128'(0));
      check_eq("mid_rst_wdf_rdy", 128'(wdf_rdy), 128'(0));
      check_eq("mid_rst_app_en", 128'(app_en), 128'(0));
      check_eq("mid_rst_wren", 128'(app_wdf_wren), 128'(0));
      check_eq("mid_rst_orphan", 128'(orphan), 128'(0));
      step();
      rst = 1'b0; wren = '0; wend = '0;
      @(negedge clk);
      check_eq("post_rst_bubble", 128'(req_rdy), 128'(0));
      step();
      @(negedge clk);
      check_eq("post_rst_addr", 128'(app_addr), 128'(28'hAAA));
      check_eq("post_rst_rdy", 128'(req_rdy), 128'(2'b01));
      if (req_rdy[0] && app_en) exp_rd_q.push_back(1'b0);
      step();
      req_en = '0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
